hps_led_sequencer: RTL and testbench
====================================

// Module: hps_led_sequencer
// PURPOSE
//  Consumes the 2-bit HPS PIO command (pio_0_external_connection_export of qsys_top) and drives board LEDs.
//  Commands are stability-filtered. Supported modes: off, on, one-hot chase, PWM breathe.
//  Sits beside qsys_top in the board top level, on the same 100 MHz fabric clock.
//  Blanks the LEDs while the HPS holds the fabric in reset (h2f_reset) or the device is not initialised (ninit_done).
// PARAMETERS
//  NUM_LEDS       4           LED count (>=2)
//  STABLE_CYCLES  1024        consecutive equal samples before a command is adopted (>=1)
//  STEP_CYCLES    25_000_000  clocks per chase step (>=1)
//  PWM_BITS       8           PWM counter/duty width
//  RAMP_CYCLES    390_625     clocks per breathe duty step (>=1)
// PORTS
//  clk_100_clk    in   1         fabric clock, 100 MHz
//  reset_reset_n  in   1         synchronous active-low reset
//  pio_cmd        in   2         from pio_0 export; 00 OFF, 01 ON, 10 CHASE, 11 BREATHE
//  h2f_reset      in   1         HPS-to-fabric reset, active-high
//  ninit_done     in   1         high until device init complete
//  led            out  NUM_LEDS  LED drive, 1 = lit, registered
//  mode_o         out  2         currently adopted mode
//  mode_change    out  1         one-cycle pulse when mode_o changes
// BEHAVIOUR
//  - Reset: sampled on rising edge when reset_reset_n=0. Clears all registers: led=0, mode_o=OFF, mode_change=0, filter/pattern counters=0.
//  - Hold: hold = h2f_reset | ninit_done, registered once. While hold_q=1, the block behaves as in reset.
//  - Filter (edge numbering: edge 1 = first edge that samples the new pio_cmd into cmd_q):
//      - If cmd_q != cand: cand<=cmd_q, cnt<=0.
//      - Else if cnt != STABLE_CYCLES-1: cnt++.
//      - Else if cand != mode_o: mode_o<=cand, mode_change<=1 for one cycle.
//    A constant new command therefore updates mode_o at edge STABLE_CYCLES+2, and led reflects it one edge later.
//    Any shorter pulse is ignored.
//  - Pattern FSM states = mode_o.
//    On every mode change, step_cnt, ramp_cnt and pwm_cnt clear, chase_vec=1, duty=0, dir=up.
//  - OFF: led=0. ON: led=all ones.
//  - CHASE:
//      - step_cnt counts 0..STEP_CYCLES-1 and wraps.
//      - At wrap, chase_vec rotates left; the MSB wraps to bit0.
//      - led = chase_vec, starting at ...0001.
//  - BREATHE:
//      - pwm_cnt free-runs modulo 2^PWM_BITS.
//      - led = all bits equal to (pwm_cnt < duty).
//      - ramp_cnt counts 0..RAMP_CYCLES-1. At wrap, duty steps by +1 (up) or -1 (down).
//      - On reaching 2^PWM_BITS-1, dir becomes down; on reaching 0, dir becomes up.
//      - Turnaround: the extreme value is held for exactly one ramp period.
//      - duty=0 gives LEDs fully off. duty=max gives LEDs lit 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
//  - All counters are unsigned, sized $clog2 of their terminal count, and never overflow past the terminal count.
//  - Simultaneous events: reset beats hold, hold beats filter, filter beats pattern.
//    A mode adoption on the same edge as a chase/ramp wrap restarts the new pattern; the wrap is discarded.
//  - Reset or hold mid-pattern: led=0 from the next edge. After release, the command is re-filtered from scratch (full latency).
// STRUCTURE
//  - Package hps_led_pkg: typedef enum logic [1:0] mode_t {MODE_OFF=0, MODE_ON=1, MODE_CHASE=2, MODE_BREATHE=3}.
//  - Sub-module hps_led_cmd_filter (cmd_q/cand/cnt/mode_o/mode_change, parameter STABLE_CYCLES).
//  - The top holds the hold register, the pattern counters and the led output register.
// TESTING (overrides: NUM_LEDS=4, STABLE_CYCLES=4, STEP_CYCLES=3, PWM_BITS=3, RAMP_CYCLES=2)
//  1. reset_reset_n=0 for 2 edges with pio_cmd=01:
//       led=0000, mode_o=00 during reset.
//       After release: mode_o=01 at edge 6, led=1111 at edge 7, single mode_change pulse.
//  2. Glitch: pio_cmd=01 for 3 cycles, then 00:
//       mode_o stays 00, mode_change never asserts, led=0000.
//  3. pio_cmd=10 held:
//       led=0001, then every 3 clocks 0010, 0100, 1000, 0001.
//  4. pio_cmd=11 held:
//       duty sequence 0,1,...,7,6,...,0,1 at 2-clock steps.
//       With duty=3, led=1111 on exactly 3 of each 8 consecutive cycles.
//  5. ninit_done=1 mid-chase (led=0100):
//       led=0000 and mode_o=00 within 2 edges.
//       After release with pio_cmd=10: mode_o=10 after 6 edges, led restarts at 0001.
//  6. Change from BREATHE to ON:
//       led=1111 on the edge after mode_o=01, one mode_change pulse, no PWM gaps afterwards.
//       Simultaneous h2f_reset=1 and reset_reset_n=0 gives the reset values.

Source files
------------

// File: rtl/hps_led_pkg.sv
// Shared types and helpers for the HPS-driven LED sequencer.
// The adopted PIO command doubles as the pattern FSM state.
package hps_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    // Counter width able to hold 0..terminal-1, never narrower than one bit
    function automatic int cnt_width(input int terminal);
        return (terminal <= 1) ? 1 : $clog2(terminal);
    endfunction

endpackage

// File: rtl/hps_led_cmd_filter.sv
// Stability filter for the 2-bit HPS PIO command; adopts a command only
// after it has been seen unchanged for STABLE_CYCLES consecutive samples.
module hps_led_cmd_filter
    import hps_led_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [1:0] pio_cmd,
    output mode_t      mode_o,
    output logic       mode_change,
    output logic       adopt
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [1:0]    cmd_q, cmd_d;
    mode_t         cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mode_t         mode_q, mode_d;
    logic          change_q, change_d;

    always_comb begin
        cmd_d    = pio_cmd;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        change_d = 1'b0;
        if (mode_t'(cmd_q) != cand_q) begin
            cand_d = mode_t'(cmd_q);
            cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cand_q != mode_q) begin
            mode_d   = cand_q;
            change_d = 1'b1;
        end
    end

    // Hold from the top clears the filter exactly like reset does
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cmd_q    <= 2'b00;
            cand_q   <= MODE_OFF;
            cnt_q    <= '0;
            mode_q   <= MODE_OFF;
            change_q <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            change_q <= change_d;
        end
    end

    assign mode_o      = mode_q;
    assign mode_change = change_q;
    assign adopt       = change_d;

endmodule

// File: rtl/hps_led_sequencer.sv
// LED pattern engine driven by the filtered HPS PIO command: off, on,
// one-hot chase and PWM breathe, blanked while the HPS holds the fabric.
module hps_led_sequencer
    import hps_led_pkg::*;
#(
    parameter int NUM_LEDS      = 4,
    parameter int STABLE_CYCLES = 1024,
    parameter int STEP_CYCLES   = 25_000_000,
    parameter int PWM_BITS      = 8,
    parameter int RAMP_CYCLES   = 390_625
) (
    input  logic                clk_100_clk,
    input  logic                reset_reset_n,
    input  logic [1:0]          pio_cmd,
    input  logic                h2f_reset,
    input  logic                ninit_done,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode_o,
    output logic                mode_change
);

    localparam int                  SW        = cnt_width(STEP_CYCLES);
    localparam int                  RW        = cnt_width(RAMP_CYCLES);
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};

    logic                hold_q, hold_d;
    mode_t               mode_cur;
    logic                adopt;
    logic [SW-1:0]       step_q, step_d;
    logic [RW-1:0]       ramp_q, ramp_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_down_q, dir_down_d;
    logic [NUM_LEDS-1:0] chase_q, chase_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    hps_led_cmd_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk        (clk_100_clk),
        .rst_n      (reset_reset_n),
        .clear      (hold_q),
        .pio_cmd    (pio_cmd),
        .mode_o     (mode_cur),
        .mode_change(mode_change),
        .adopt      (adopt)
    );

    always_comb begin
        hold_d     = h2f_reset | ninit_done;
        step_d     = step_q;
        ramp_d     = ramp_q;
        pwm_d      = pwm_q;
        duty_d     = duty_q;
        dir_down_d = dir_down_q;
        chase_d    = chase_q;
        led_d      = '0;

        // A newly adopted mode restarts every pattern and swallows any wrap on this edge
        if (adopt) begin
            step_d     = '0;
            ramp_d     = '0;
            pwm_d      = '0;
            duty_d     = '0;
            dir_down_d = 1'b0;
            chase_d    = NUM_LEDS'(1);
        end else begin
            case (mode_cur)
                MODE_CHASE: begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                MODE_BREATHE: begin
                    pwm_d = pwm_q + 1'b1;
                    if (ramp_q == RAMP_LAST) begin
                        ramp_d = '0;
                        // Turn around on arrival so each extreme lasts one ramp period
                        if (!dir_down_q) begin
                            duty_d = duty_q + 1'b1;
                            if (duty_d == DUTY_MAX) dir_down_d = 1'b1;
                        end else begin
                            duty_d = duty_q - 1'b1;
                            if (duty_d == '0) dir_down_d = 1'b0;
                        end
                    end else begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        case (mode_cur)
            MODE_OFF:     led_d = '0;
            MODE_ON:      led_d = '1;
            MODE_CHASE:   led_d = chase_q;
            MODE_BREATHE: led_d = {NUM_LEDS{pwm_q < duty_q}};
            default:      led_d = '0;
        endcase
    end

    always_ff @(posedge clk_100_clk) begin
        if (!reset_reset_n || hold_q) begin
            hold_q     <= reset_reset_n ? hold_d : 1'b0;
            step_q     <= '0;
            ramp_q     <= '0;
            pwm_q      <= '0;
            duty_q     <= '0;
            dir_down_q <= 1'b0;
            chase_q    <= '0;
            led_q      <= '0;
        end else begin
            hold_q     <= hold_d;
            step_q     <= step_d;
            ramp_q     <= ramp_d;
            pwm_q      <= pwm_d;
            duty_q     <= duty_d;
            dir_down_q <= dir_down_d;
            chase_q    <= chase_d;
            led_q      <= led_d;
        end
    end

    assign led    = led_q;
    assign mode_o = mode_cur;

endmodule

// File: tb/tb_hps_led_sequencer.sv
// Directed bench for hps_led_sequencer with small parameters so every
// filter, chase and breathe timing can be checked cycle by cycle.
module tb_hps_led_sequencer;

    logic       clk = 1'b0;
    logic       reset_reset_n;
    logic [1:0] pio_cmd;
    logic       h2f_reset;
    logic       ninit_done;
    logic [3:0] led;
    logic [1:0] mode_o;
    logic       mode_change;

    int assertions = 0;
    int failures   = 0;
    int pulses;

    always #5 clk = ~clk;

    hps_led_sequencer #(
        .NUM_LEDS     (4),
        .STABLE_CYCLES(4),
        .STEP_CYCLES  (3),
        .PWM_BITS     (3),
        .RAMP_CYCLES  (2)
    ) dut (
        .clk_100_clk  (clk),
        .reset_reset_n(reset_reset_n),
        .pio_cmd      (pio_cmd),
        .h2f_reset    (h2f_reset),
        .ninit_done   (ninit_done),
        .led          (led),
        .mode_o       (mode_o),
        .mode_change  (mode_change)
    );

    task automatic applyStimulus(input logic rst_n, input logic [1:0] cmd,
                                 input logic h2f, input logic ninit);
        reset_reset_n = rst_n;
        pio_cmd       = cmd;
        h2f_reset     = h2f;
        ninit_done    = ninit;
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Triangle duty sequence 0..7..0..: one entry per 2-clock ramp period
    function automatic int duty_at(input int idx);
        if (idx <= 7)  return idx;
        if (idx <= 14) return 14 - idx;
        return idx - 14;
    endfunction

    initial begin
        int m;
        logic [3:0] exp_led;

        // Reset with ON requested, then full filter latency after release
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        tick(1);
        checkOutput("reset led e1", 8'(led), 8'h0);
        checkOutput("reset mode e1", 8'(mode_o), 8'h0);
        tick(1);
        checkOutput("reset led e2", 8'(led), 8'h0);
        checkOutput("reset mode e2", 8'(mode_o), 8'h0);
        checkOutput("reset mc e2", 8'(mode_change), 8'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            pulses += int'(mode_change);
            if (k == 5) checkOutput("on mode before e6", 8'(mode_o), 8'h0);
            if (k == 6) begin
                checkOutput("on mode e6", 8'(mode_o), 8'h1);
                checkOutput("on mc e6", 8'(mode_change), 8'h1);
                checkOutput("on led e6", 8'(led), 8'h0);
            end
            if (k >= 7) checkOutput($sformatf("on led e%0d", k), 8'(led), 8'hF);
        end
        checkOutput("on pulse count", 8'(pulses), 8'd1);

        // Three-cycle glitch from OFF must be ignored
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        tick(2);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        pulses = 0;
        tick(3);
        pulses += int'(mode_change);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            pulses += int'(mode_change);
            checkOutput($sformatf("glitch mode e%0d", k), 8'(mode_o), 8'h0);
            checkOutput($sformatf("glitch led e%0d", k), 8'(led), 8'h0);
        end
        checkOutput("glitch pulse count", 8'(pulses), 8'd0);

        // Chase: 0001 from the edge after adoption, rotating every 3 clocks
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            tick(1);
            if (k == 6) checkOutput("chase mode e6", 8'(mode_o), 8'h2);
            if (k >= 7) begin
                exp_led = 4'b0001 << (((k - 7) / 3) % 4);
                checkOutput($sformatf("chase led e%0d", k), 8'(led), 8'(exp_led));
            end
        end

        // ninit_done mid-chase (led currently 0100) blanks within two edges
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
        tick(2);
        checkOutput("hold led", 8'(led), 8'h0);
        checkOutput("hold mode", 8'(mode_o), 8'h0);
        tick(1);
        checkOutput("hold led later", 8'(led), 8'h0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            if (k == 6) checkOutput("rehold mode before", 8'(mode_o), 8'h0);
            if (k == 7) checkOutput("rehold mode adopted", 8'(mode_o), 8'h2);
            if (k >= 8 && k <= 10) checkOutput($sformatf("rehold led e%0d", k), 8'(led), 8'h1);
            if (k == 11) checkOutput("rehold led step", 8'(led), 8'h2);
        end

        // Breathe: led(j) reflects pwm=(j-1)%8 against duty of ramp period (j-1)/2
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (k == 5) checkOutput("breathe mode before", 8'(mode_o), 8'h2);
            if (k == 6) checkOutput("breathe mode e6", 8'(mode_o), 8'h3);
            if (k >= 7) begin
                m = k - 7;
                exp_led = ((m % 8) < duty_at(m / 2)) ? 4'hF : 4'h0;
                checkOutput($sformatf("breathe led j%0d", k - 6), 8'(led), 8'(exp_led));
            end
        end

        // Breathe to ON: solid LEDs from the edge after adoption
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            pulses += int'(mode_change);
            if (k == 6) checkOutput("b2on mode e6", 8'(mode_o), 8'h1);
            if (k >= 7) checkOutput($sformatf("b2on led e%0d", k), 8'(led), 8'hF);
        end
        checkOutput("b2on pulse count", 8'(pulses), 8'd1);

        // Reset and h2f_reset together: reset values, then held blank
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
        tick(1);
        checkOutput("rst+h2f led", 8'(led), 8'h0);
        checkOutput("rst+h2f mode", 8'(mode_o), 8'h0);
        checkOutput("rst+h2f mc", 8'(mode_change), 8'h0);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
        tick(8);
        checkOutput("h2f held led", 8'(led), 8'h0);
        checkOutput("h2f held mode", 8'(mode_o), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
